alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 179 +++++++++++++++++
 tb/tb_alu_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined ALU: one-entry operand stage S1 feeding a two-entry in-order result
// buffer with valid/ready handshakes on both sides and a consumed-result counter.
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Resetb,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Illegal,
  output logic [15:0]      OpCount
);

  localparam int EW = WIDTH + 2;
  typedef logic [EW-1:0] entry_t;

  // Packs {zero, illegal, result}; undefined codes yield a zero result flagged illegal.
  function automatic entry_t alu_eval(input logic [3:0] ctrl,
                                      input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic             ill;
    r   = '0;
    ill = 1'b0;
    case (ctrl)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = a + b;
      4'd6:    r = a - b;
      4'd7:    r = b;
      default: begin
        r   = '0;
        ill = 1'b1;
      end
    endcase
    return {(r == '0), ill, r};
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [3:0]       s1_ctrl_q, s1_ctrl_d;
  entry_t           buf_q [0:1];
  entry_t           buf_d [0:1];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] bus_w_q, bus_w_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [15:0]      op_count_q, op_count_d;

  logic             pop_s;
  logic             push_s;
  logic             full_s;
  logic             accept_s;
  entry_t           s1_result_s;
  entry_t           head_s;

  // Handshake decode; InReady is forced low while reset is held.
  always_comb begin
    pop_s       = out_valid_q & OutReady;
    full_s      = (count_q == 2'd2);
    push_s      = s1_valid_q & (~full_s | pop_s);
    InReady     = Resetb & (~s1_valid_q | ~full_s | pop_s);
    accept_s    = InValid & InReady;
    s1_result_s = alu_eval(s1_ctrl_q, s1_a_q, s1_b_q);
  end

  // Operand stage: load on accept, empty once its result moves to the buffer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_ctrl_d  = s1_ctrl_q;
    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_a_d     = BusA;
      s1_b_d     = BusB;
      s1_ctrl_d  = ALUCtrl;
    end else if (push_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Result buffer bookkeeping; the output registers track the post-edge head
  // and keep their last value once the buffer drains.
  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      buf_d[wr_ptr_q] = s1_result_s;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    head_s      = buf_d[rd_ptr_d];
    out_valid_d = (count_d != 2'd0);
    if (count_d != 2'd0) begin
      bus_w_d   = head_s[WIDTH-1:0];
      illegal_d = head_s[WIDTH];
      zero_d    = head_s[WIDTH+1];
    end else begin
      bus_w_d   = bus_w_q;
      illegal_d = illegal_q;
      zero_d    = zero_q;
    end
    if (pop_s) begin
      op_count_d = op_count_q + 16'd1;
    end else begin
      op_count_d = op_count_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or negedge Resetb) begin
    if (!Resetb) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_ctrl_q   <= 4'd0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      out_valid_q <= 1'b0;
      bus_w_q     <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      op_count_q  <= 16'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_ctrl_q   <= s1_ctrl_d;
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      bus_w_q     <= bus_w_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      op_count_q  <= op_count_d;
    end
  end

  assign OutValid = out_valid_q;
  assign BusW     = bus_w_q;
  assign Zero     = zero_q;
  assign Illegal  = illegal_q;
  assign OpCount  = op_count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: issued ops push a model result, a negedge
// monitor compares the presented head and pops on each consumed result.
module tb_alu_pipe;

  logic        CLK;
  logic        Resetb;
  logic        InValid;
  logic        InReady;
  logic [63:0] BusA;
  logic [63:0] BusB;
  logic [3:0]  ALUCtrl;
  logic        OutValid;
  logic        OutReady;
  logic [63:0] BusW;
  logic        Zero;
  logic        Illegal;
  logic [15:0] OpCount;

  logic [65:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          pops = 0;
  int          cyc = 0;
  logic        rand_rdy = 1'b0;
  logic        fixed_rdy = 1'b1;

  alu_pipe #(.WIDTH(64)) dut (
    .CLK(CLK), .Resetb(Resetb), .InValid(InValid), .InReady(InReady),
    .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .OutValid(OutValid),
    .OutReady(OutReady), .BusW(BusW), .Zero(Zero), .Illegal(Illegal),
    .OpCount(OpCount)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Reference result {zero, illegal, result} straight from the opcode table.
  function automatic logic [65:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                         input logic [3:0] c);
    logic [63:0] r;
    logic        ill;
    ill = 1'b0;
    case (c)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = a + b;
      4'd6:    r = a - b;
      4'd7:    r = b;
      default: begin r = 64'd0; ill = 1'b1; end
    endcase
    return {r == 64'd0, ill, r};
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_outvalid"}, 66'(OutValid), 66'd0);
    chk({tag, "_busw"}, 66'(BusW), 66'd0);
    chk({tag, "_flags"}, 66'({Zero, Illegal}), 66'd0);
    chk({tag, "_opcount"}, 66'(OpCount), 66'd0);
    chk({tag, "_inready"}, 66'(InReady), 66'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #5 Resetb = 1'b0;
    #1 reset_checks("rst");
    @(negedge CLK);
    #5 Resetb = 1'b1;
    #1 chk("inready_after_rst", 66'(InReady), 66'd1);
  endtask

  // Present one op, wait (bounded) for acceptance, record expectation.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
    int n;
    @(negedge CLK);
    InValid = 1'b1; BusA = a; BusB = b; ALUCtrl = c;
    #1;
    n = 0;
    while (!InReady && n < 200) begin
      @(negedge CLK); #1; n++;
    end
    if (!InReady) begin
      chk("accept_timeout", 66'(InReady), 66'd1);
      InValid = 1'b0;
    end else begin
      exp_q.push_back(ref_op(a, b, c));
      @(posedge CLK); #1;
      InValid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge CLK); n++;
    end
    #3;
    chk("drain_left", 66'(exp_q.size()), 66'd0);
  endtask

  // Sole driver of OutReady: random or fixed, changed only at the falling edge.
  initial begin
    OutReady = 1'b1;
    forever begin
      @(negedge CLK);
      OutReady = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
    end
  end

  // Monitor: compare head while valid, pop when the consumer takes it.
  always @(negedge CLK) begin
    #2;
    if (!Resetb) begin
      exp_q.delete();
      pops = 0;
    end else begin
      chk("opcount", 66'(OpCount), 66'(pops & 32'hFFFF));
      if (OutValid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: got %h, want no result", {Zero, Illegal, BusW});
        end else begin
          chk("head", {Zero, Illegal, BusW}, exp_q[0]);
          if (OutReady) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] a, b;
    logic [3:0]  c;
    int          c0, c1;
    CLK = 1'b0; Resetb = 1'b1; InValid = 1'b0;
    BusA = 64'd0; BusB = 64'd0; ALUCtrl = 4'd0;
    #2 Resetb = 1'b0;
    #1 reset_checks("por");
    repeat (3) @(negedge CLK);
    #5 Resetb = 1'b1;
    #1 chk("inready_after_por", 66'(InReady), 66'd1);

    // ADD latency and first pop
    issue(64'h7, 64'h3, 4'd2);
    @(posedge CLK); #1;
    chk("lat_outvalid", 66'(OutValid), 66'd1);
    chk("lat_busw", 66'(BusW), 66'hA);
    chk("lat_flags", 66'({Zero, Illegal}), 66'd0);
    @(posedge CLK); #1;
    chk("opcount_first", 66'(OpCount), 66'd1);

    // SUB to zero and SUB borrow
    issue(64'h5, 64'h5, 4'd6);
    issue(64'h0, 64'h1, 4'd6);
    drain();

    // Back-pressure fills buffer and S1
    fixed_rdy = 1'b0;
    @(negedge CLK);
    issue(64'h5, 64'h7, 4'd0);
    issue(64'h7, 64'h0, 4'd1);
    issue(64'hB, 64'hF, 4'd7);
    chk("full_inready", 66'(InReady), 66'd0);
    repeat (3) @(posedge CLK);
    #1 chk("held_inready", 66'(InReady), 66'd0);
    fixed_rdy = 1'b1;
    drain();
    chk("inready_back", 66'(InReady), 66'd1);

    // Undefined code then a legal one
    issue(64'h8, 64'h8, 4'd3);
    issue(64'h8, 64'h8, 4'd0);
    drain();

    // Reset with results buffered
    fixed_rdy = 1'b0;
    @(negedge CLK);
    issue(64'h1, 64'h2, 4'd2);
    issue(64'h3, 64'h4, 4'd6);
    @(posedge CLK); #1;
    chk("buffered_before_rst", 66'(OutValid), 66'd1);
    fixed_rdy = 1'b1;
    do_reset();
    repeat (6) @(negedge CLK);
    #3 chk("no_stale", 66'(OutValid), 66'd0);

    // Randomized traffic with random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) a = 64'hFFFF_FFFF_FFFF_FFFF;
      case ($urandom_range(0, 6))
        0: c = 4'd0;
        1: c = 4'd1;
        2: c = 4'd2;
        3: c = 4'd6;
        4: c = 4'd7;
        default: c = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 3) == 0) @(negedge CLK);
      issue(a, b, c);
    end
    rand_rdy = 1'b0;
    fixed_rdy = 1'b1;
    drain();

    // Full-rate streaming across the counter wrap
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 70000; i++) begin
      issue({$urandom, $urandom}, {32'd0, 32'(i)}, 4'd7);
    end
    c1 = cyc;
    chk("stream_cycles", 66'(c1 - c0), 66'd70000);
    drain();
    chk("opcount_wrap", 66'(OpCount), 66'd4464);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
